adc_scan_sequencer: RTL and testbench

Scan controller for the `adc_capture` SPI ADC front end. It steps through an enabled subset of the 8 ADC channels on a periodic tick or a software start. For each channel it drives the `ctl_valid`/`address` request and completes the 4-phase `adc_ready`/`adc_ack` handshake. Each 12-bit result is latched into a per-channel result bank and also emitted as a one-cycle result strobe. It replaces the free-running ack logic in the board top level and sits between `adc_capture` and the LED/debug or downstream consumer logic.

---
 rtl/adc_seq_pkg.sv | 30 +++
 rtl/adc_seq_tick.sv | 33 +++
 rtl/adc_scan_sequencer.sv | 163 ++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | adc_seq_pkg - shared types/constants for the ADC scan sequencer  rev 1.0 |
// +-------------------------------------------------------------------------+
package adc_seq_pkg;

   localparam int N_CH   = 8;
   localparam int CH_W   = 3;
   localparam int DATA_W = 12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACK  = 2'd2
   } seq_state_t;

   // Index of the least-significant set bit; 0 when the mask is empty.
   function automatic logic [CH_W-1:0] lowest_set(input logic [N_CH-1:0] mask);
      logic [CH_W-1:0] idx;
      idx = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (mask[i]) begin
            idx = CH_W'(i);
         end
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/adc_seq_tick.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | adc_seq_tick - free-running periodic tick, fires at count P-1    rev 1.0 |
// +-------------------------------------------------------------------------+
module adc_seq_tick #(
   parameter int clk_hz  = 25000000,
   parameter int scan_hz = 1000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int P     = (clk_hz / scan_hz < 1) ? 1 : clk_hz / scan_hz;
   localparam int CNT_W = (P > 1) ? $clog2(P) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(P - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/adc_scan_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | adc_scan_sequencer - masked channel scan over adc_capture hshake rev 1.0 |
// +-------------------------------------------------------------------------+
module adc_scan_sequencer
   import adc_seq_pkg::*;
#(
   parameter int clk_hz         = 25000000,
   parameter int scan_hz        = 1000,
   parameter int timeout_cycles = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              start,
   input  logic [N_CH-1:0]   ch_mask,
   output logic              ctl_valid,
   output logic [CH_W-1:0]   address,
   input  logic              adc_ready,
   input  logic [DATA_W-1:0] d_signal,
   output logic              adc_ack,
   output logic              result_valid,
   output logic [CH_W-1:0]   result_ch,
   output logic [DATA_W-1:0] result_data,
   input  logic [CH_W-1:0]   rd_ch,
   output logic [DATA_W-1:0] rd_data,
   output logic              scan_done,
   output logic              busy,
   output logic              timeout_err,
   output logic              overrun_err,
   input  logic              clear_err
);

   localparam int TO_W = $clog2(timeout_cycles + 1);
   localparam logic [TO_W-1:0] TO_MAX  = TO_W'(timeout_cycles);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(timeout_cycles - 1);

   seq_state_t        state;
   logic [N_CH-1:0]   pend;
   logic [TO_W-1:0]   wait_cnt;
   logic [DATA_W-1:0] bank [N_CH];

   logic              tick;
   logic              trig;
   logic              wait_expired;
   logic              leave;
   logic [N_CH-1:0]   pend_left;

   adc_seq_tick #(
      .clk_hz  (clk_hz),
      .scan_hz (scan_hz)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // start and tick on the same cycle collapse into one trigger
   assign trig         = start | (tick & enable);
   assign busy         = (state != ST_IDLE);
   assign pend_left    = pend & ~(N_CH'(1) << address);
   assign wait_expired = (wait_cnt == TO_LAST);
   assign rd_data      = bank[rd_ch];

   // Leaving the current channel: normal ACK release, or a timeout in REQ/ACK.
   assign leave = ((state == ST_REQ) && !adc_ready && wait_expired) ||
                  ((state == ST_ACK) && (!adc_ready || wait_expired));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         pend         <= '0;
         wait_cnt     <= '0;
         ctl_valid    <= 1'b0;
         address      <= '0;
         adc_ack      <= 1'b0;
         result_valid <= 1'b0;
         result_ch    <= '0;
         result_data  <= '0;
         scan_done    <= 1'b0;
         timeout_err  <= 1'b0;
         overrun_err  <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            bank[i] <= '0;
         end
      end else begin
         result_valid <= 1'b0;
         scan_done    <= 1'b0;

         if (wait_cnt != TO_MAX) begin
            wait_cnt <= wait_cnt + TO_W'(1);
         end

         // set events are assigned later in this block so they beat clear_err
         if (clear_err) begin
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
         end
         if (trig && busy) begin
            overrun_err <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (trig) begin
                  wait_cnt <= '0;
                  pend     <= ch_mask;
                  if (ch_mask != '0) begin
                     address   <= lowest_set(ch_mask);
                     ctl_valid <= 1'b1;
                     state     <= ST_REQ;
                  end else begin
                     scan_done <= 1'b1;
                  end
               end
            end
            ST_REQ: begin
               if (adc_ready) begin
                  bank[address] <= d_signal;
                  result_valid  <= 1'b1;
                  result_ch     <= address;
                  result_data   <= d_signal;
                  ctl_valid     <= 1'b0;
                  adc_ack       <= 1'b1;
                  pend          <= pend_left;
                  wait_cnt      <= '0;
                  state         <= ST_ACK;
               end else if (wait_expired) begin
                  timeout_err <= 1'b1;
                  ctl_valid   <= 1'b0;
               end
            end
            ST_ACK: begin
               if (adc_ready && wait_expired) begin
                  timeout_err <= 1'b1;
               end
               if (leave) begin
                  adc_ack <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase

         // Shared continuation: next pending channel, or end of scan.
         if (leave) begin
            pend     <= pend_left;
            wait_cnt <= '0;
            if (pend_left != '0) begin
               address   <= lowest_set(pend_left);
               ctl_valid <= 1'b1;
               state     <= ST_REQ;
            end else begin
               scan_done <= 1'b1;
               state     <= ST_IDLE;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_adc_scan_sequencer - directed bench for adc_scan_sequencer    rev 1.0 |
// +-------------------------------------------------------------------------+
module tb_adc_scan_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        start;
   logic [7:0]  ch_mask;
   logic        ctl_valid;
   logic [2:0]  address;
   logic        adc_ready;
   logic [11:0] d_signal;
   logic        adc_ack;
   logic        result_valid;
   logic [2:0]  result_ch;
   logic [11:0] result_data;
   logic [2:0]  rd_ch;
   logic [11:0] rd_data;
   logic        scan_done;
   logic        busy;
   logic        timeout_err;
   logic        overrun_err;
   logic        clear_err;

   int n_vec = 0;
   int n_err = 0;
   int rv_cnt = 0;
   int overlap_cnt = 0;

   adc_scan_sequencer #(
      .clk_hz         (1000),
      .scan_hz        (100),
      .timeout_cycles (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .start        (start),
      .ch_mask      (ch_mask),
      .ctl_valid    (ctl_valid),
      .address      (address),
      .adc_ready    (adc_ready),
      .d_signal     (d_signal),
      .adc_ack      (adc_ack),
      .result_valid (result_valid),
      .result_ch    (result_ch),
      .result_data  (result_data),
      .rd_ch        (rd_ch),
      .rd_data      (rd_data),
      .scan_done    (scan_done),
      .busy         (busy),
      .timeout_err  (timeout_err),
      .overrun_err  (overrun_err),
      .clear_err    (clear_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (result_valid) rv_cnt <= rv_cnt + 1;
      if (ctl_valid && adc_ack) overlap_cnt <= overlap_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // ADC model: answer the current request for channel ch after dly cycles.
   task automatic serve(input logic [2:0] ch, input logic [11:0] data, input int dly);
      int n;
      n = 0;
      while (!ctl_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("req", ctl_valid, 1);
      chk("addr", address, ch);
      repeat (dly) @(negedge clk);
      chk("addr_hold", {ctl_valid, address}, {1'b1, ch});
      adc_ready = 1'b1;
      d_signal  = data;
      @(negedge clk);
      chk("ack_hi", {adc_ack, ctl_valid, result_valid}, 3'b101);
      chk("res_ch", result_ch, ch);
      chk("res_data", result_data, data);
      adc_ready = 1'b0;
      d_signal  = '0;
      @(negedge clk);
      chk("ack_lo", adc_ack, 0);
   endtask

   initial begin
      int base;
      int n;
      int sd;
      int cv;
      rst_n = 1'b0; enable = 1'b0; start = 1'b0; ch_mask = '0;
      adc_ready = 1'b0; d_signal = '0; rd_ch = '0; clear_err = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ctl", {ctl_valid, adc_ack, busy, result_valid, scan_done}, 0);
      chk("rst_err", {timeout_err, overrun_err}, 0);
      chk("rst_addr", address, 0);
      chk("rst_bank", rd_data, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // single channel
      base = rv_cnt;
      ch_mask = 8'h04;
      pulse_start();
      chk("busy1", busy, 1);
      serve(3'd2, 12'hABC, 5);
      chk("done1", scan_done, 1);
      rd_ch = 3'd2;
      #1;
      chk("bank2", rd_data, 12'hABC);
      chk("rv1", rv_cnt - base, 1);
      @(negedge clk);
      chk("idle1", {busy, scan_done}, 0);

      // multi channel, ordered 0,4,7
      base = rv_cnt;
      ch_mask = 8'h91;
      pulse_start();
      serve(3'd0, 12'h100, 1);
      chk("mid_done", scan_done, 0);
      serve(3'd4, 12'h404, 2);
      serve(3'd7, 12'h7F7, 0);
      chk("done2", scan_done, 1);
      chk("rv2", rv_cnt - base, 3);
      rd_ch = 3'd4;
      #1;
      chk("bank4", rd_data, 12'h404);
      rd_ch = 3'd7;
      #1;
      chk("bank7", rd_data, 12'h7F7);

      // periodic ticks with an empty mask
      @(negedge clk);
      ch_mask = 8'h00;
      enable  = 1'b1;
      n = 0;
      while (!scan_done && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("tick_first", scan_done, 1);
      sd = 0; cv = 0;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         sd += int'(scan_done);
         cv += int'(ctl_valid | busy);
      end
      @(negedge clk);
      chk("tick_gap", sd, 0);
      chk("tick_period", scan_done, 1);
      chk("tick_noreq", cv, 0);
      enable = 1'b0;
      @(negedge clk);

      // timeout on channel 1
      ch_mask = 8'h02;
      pulse_start();
      serve(3'd1, 12'h5A5, 2);
      chk("done_c1", scan_done, 1);
      base = rv_cnt;
      ch_mask = 8'h03;
      pulse_start();
      serve(3'd0, 12'h111, 1);
      chk("to_req", {ctl_valid, address}, {1'b1, 3'd1});
      repeat (15) @(negedge clk);
      chk("to_early", {timeout_err, ctl_valid}, 2'b01);
      @(negedge clk);
      chk("to_set", {timeout_err, ctl_valid, result_valid}, 3'b100);
      chk("to_done", scan_done, 1);
      rd_ch = 3'd1;
      #1;
      chk("to_bank", rd_data, 12'h5A5);
      chk("to_rv", rv_cnt - base, 1);
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      chk("to_clr", timeout_err, 0);

      // overrun
      base = rv_cnt;
      ch_mask = 8'h03;
      pulse_start();
      chk("ov_pre", overrun_err, 0);
      pulse_start();
      chk("ov_set", overrun_err, 1);
      chk("ov_hold", {ctl_valid, address}, {1'b1, 3'd0});
      serve(3'd0, 12'h0A0, 1);
      serve(3'd1, 12'h1B1, 0);
      chk("ov_done", scan_done, 1);
      chk("ov_rv", rv_cnt - base, 2);
      @(negedge clk);
      chk("ov_idle", busy, 0);
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      chk("ov_clr", overrun_err, 0);

      // reset during ACK
      ch_mask = 8'h06;
      pulse_start();
      chk("rs_addr", address, 1);
      adc_ready = 1'b1;
      d_signal  = 12'h777;
      @(negedge clk);
      chk("rs_ack", adc_ack, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rs_out", {ctl_valid, adc_ack, busy, result_valid, scan_done, timeout_err, overrun_err}, 0);
      chk("rs_addr0", address, 0);
      rd_ch = 3'd2;
      #1;
      chk("rs_bank", rd_data, 0);
      adc_ready = 1'b0;
      d_signal  = '0;
      rst_n = 1'b1;
      @(negedge clk);
      pulse_start();
      serve(3'd1, 12'h321, 1);
      serve(3'd2, 12'h654, 2);
      chk("rs_done", scan_done, 1);
      rd_ch = 3'd1;
      #1;
      chk("rs_bank1", rd_data, 12'h321);

      @(negedge clk);
      chk("no_overlap", overlap_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
